// File: rtl/simplez_pkg.sv
// Shared definitions for the Simplez serial I/O blocks.
// The receiver and the display transmitter both use these.
package simplez_pkg;

  localparam int UART_DEFAULT_DIVISOR = 87;
  localparam int UART_DATA_BITS       = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_rx_state_t;

endpackage

// File: rtl/simplez_sync2.sv
// Two-flop synchroniser for asynchronous pins.
// Resets to 1 so that an idle-high line does not produce a spurious edge.
module simplez_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= 1'b1;
      q       <= 1'b1;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/simplez_uart_rx.sv
// 8N1 UART receiver for the Simplez keyboard input port.
// The processor polls valid and pulses rd to consume the byte in data.
module simplez_uart_rx
  import simplez_pkg::*;
#(
  parameter int DIVISOR = UART_DEFAULT_DIVISOR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data,
  output logic       valid,
  output logic       overrun,
  output logic       frame_err
);

  localparam logic [15:0] DIV_LOAD  = 16'(DIVISOR);
  localparam logic [15:0] HALF_LOAD = 16'(DIVISOR / 2);
  localparam logic [2:0]  LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  logic                      rx_p;
  uart_rx_state_t            state;
  logic [15:0]               cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      cnt_done;
  logic                      rd_hit;

  assign cnt_done = (cnt == 16'd1);
  assign rd_hit   = rd & valid;

  simplez_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) rx_p <= 1'b1;
    else     rx_p <= rx_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rd_hit) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
      case (state)
        RX_IDLE: begin
          if (!rx_s && rx_p) begin
            cnt   <= HALF_LOAD;
            state <= RX_START;
          end
        end
        // Sampling at half a bit re-centres all later samples mid-bit.
        RX_START: begin
          if (cnt_done) begin
            if (!rx_s) begin
              bit_idx <= '0;
              cnt     <= DIV_LOAD;
              state   <= RX_DATA;
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt_done) begin
            shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
            cnt     <= DIV_LOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) state <= RX_STOP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        // Leaving mid stop bit lets a back-to-back start edge be caught.
        RX_STOP: begin
          if (cnt_done) begin
            state <= RX_IDLE;
            if (rx_s) begin
              data      <= shift;
              valid     <= 1'b1;
              overrun   <= rd_hit ? 1'b0 : (overrun | valid);
              frame_err <= 1'b0;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: doc/simplez_uart_rx.md
# simplez_uart_rx

Serial receiver for the Simplez keyboard input path: it deserialises 8N1 UART frames arriving on the `rx` pin and presents each byte to the Simplez processor's input port as a data register plus a ready flag. The processor polls `valid`, then pulses `rd` to consume the byte. It is the receive-side counterpart of the Simplez display transmitter and sits between `ui_in[0]` and the processor core inside the top level.

## Interface
Parameters:
- `DIVISOR`, default 87: clock cycles per bit (10 MHz / 115200). Legal range 4..65535.

Ports:
- `clk`  input  1  system clock; the only clock.
- `rst`  input  1  reset, synchronous, active-high.
- `rx`  input  1  asynchronous serial line, idle high.
- `rd`  input  1  one-cycle read strobe from the processor; consumes the current byte.
- `data`  output  8  last correctly framed byte, LSB = first received bit.
- `valid`  output  1  an unread byte is present in `data`.
- `overrun`  output  1  a byte was overwritten before being read.
- `frame_err`  output  1  the most recent frame had a low stop bit.

## Operation
- Input conditioning:
  - `rx` passes through a 2-flop synchroniser, giving `rx_s`.
  - A third flop gives `rx_p`, the previous value of `rx_s`.
  - All three flops reset to 1.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: when `rx_s`=0 and `rx_p`=1 (falling edge), load the counter with H = floor(DIVISOR/2) and go to START.
- START: at the end of the count, sample `rx_s`.
  - If 0: clear the bit index, reload DIVISOR and go to DATA.
  - If 1: false start; return to IDLE and change no output.
- DATA: at each end of count, shift `rx_s` in LSB-first and reload DIVISOR. After bit index 7, go to STOP.
- STOP: at the end of count, sample `rx_s` and return to IDLE on the same edge.
  - Stop = 1:
    - load `data` from the shift register and set `valid`=1;
    - set `overrun`=1 if `valid` was already 1 and `rd` is low;
    - clear `frame_err`.
  - Stop = 0: set `frame_err`=1; `data` and `valid` are unchanged.
- `rd`=1 clears `valid` and `overrun` on the next edge. `rd` while `valid`=0 has no effect.
- Simultaneous `rd` and stop-bit acceptance: the new byte wins. `valid` stays 1, `data` is the new byte, and `overrun` is not set.
- Line held low (break):
  - one edge produces one frame, ending in `frame_err`;
  - IDLE then waits for `rx_s` to return high before a new edge is accepted;
  - a line held low at reset release counts as one edge.
- Counter width is 16 bits. It counts down and the end-of-count condition is 1.

## Timing
- All outputs reset to 0; FSM resets to IDLE; counter, bit index and shift register reset to 0.
- Reset mid-frame discards the partial byte with no flag set.
- Let t be the first cycle with `rx_s`=0 in IDLE. `rx_s` lags the `rx` pin by 2 cycles.
  - start-bit sample at t+H;
  - data bit i sample at t+H+(i+1)·DIVISOR;
  - stop-bit sample at t+H+9·DIVISOR;
  - `data`, `valid` and `frame_err` change at t+H+9·DIVISOR+1.
- Back-to-back frames: the FSM is in IDLE half a bit before the stop bit ends, so a start edge immediately after the stop bit is caught.
- `rd` to `valid` low: 1 cycle. Outputs are registered, with no combinational paths from inputs.

## Structure
- `simplez_pkg` holds:
  - the FSM state typedef (`uart_rx_state_t`);
  - `UART_DEFAULT_DIVISOR` = 87;
  - `UART_DATA_BITS` = 8, shared with the transmitter.
- Sub-module `simplez_sync2`: a 2-flop synchroniser with reset value 1, reused for any other asynchronous pins.
- The counter, FSM and output registers stay in `simplez_uart_rx`.

## Test plan
All scenarios use DIVISOR=16, so H=8.
- Frame 0x41 (bits 1,0,0,0,0,0,1,0, stop 1):
  - `valid` rises exactly at t+153 with `data`=0x41, `frame_err`=0;
  - `rd` pulse → `valid`=0 next cycle.
- Glitch (`rx` low for 4 cycles, then high): FSM returns to IDLE after the start sample; `valid`, `data` and `frame_err` are unchanged.
- Frame 0x55 with the stop bit forced low: `frame_err`=1, `valid` stays 0, `data` keeps its previous value.
- Overrun and simultaneous read:
  - 0x12 then 0x34 back-to-back with no `rd` → `data`=0x34, `valid`=1, `overrun`=1;
  - repeat with `rd` asserted on the cycle 0x34 is accepted → `overrun`=0, `valid`=1.
- Assert `rst` for 1 cycle at bit 4 of frame 0xA5:
  - all outputs are 0 the next cycle;
  - the remaining bits are ignored until the next falling edge;
  - a following 0x5A is received correctly.
